// File: rtl/muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; 33 cycles from start edge to result.
// No backpressure: start is ignored while busy, and cancel aborts without touching HI/LO.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            cancel,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic                dz_q, dz_d;
    logic [XLEN-1:0]     rs_q, rs_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   p_q, p_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_zero_q, div_zero_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;

    logic [XLEN-1:0]     abs_rs, abs_rt;
    logic [XLEN:0]       msum;
    logic [XLEN:0]       dsh;
    logic [XLEN-1:0]     ddiff;
    logic                dge;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem;

    always_comb begin
        abs_rs = (!op[0] && rs_val[XLEN-1]) ? -rs_val : rs_val;
        abs_rt = (!op[0] && rt_val[XLEN-1]) ? -rt_val : rt_val;

        // Shift-add step: {acc, mplier} >> 1 with the carry of acc + mcand.
        msum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        // Restoring step: remainder shifted left with the next dividend bit.
        dsh   = p_q[2*XLEN-1:XLEN-1];
        dge   = (dsh >= {1'b0, b_q});
        ddiff = dsh[XLEN-1:0] - b_q;

        prod = neg_q  ? -p_q              : p_q;
        quot = neg_q  ? -p_q[XLEN-1:0]    : p_q[XLEN-1:0];
        rem  = rneg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];

        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        rs_d       = rs_q;
        b_d        = b_q;
        p_d        = p_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start && !cancel) begin
                    is_div_d = op[1];
                    neg_d    = !op[0] && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                    rneg_d   = !op[0] && rs_val[XLEN-1];
                    dz_d     = op[1] && (rt_val == '0);
                    rs_d     = rs_val;
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                    b_d      = op[1] ? abs_rt : abs_rs;
                    p_d      = {{XLEN{1'b0}}, (op[1] ? abs_rs : abs_rt)};
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q)
                        p_d = {(dge ? ddiff : dsh[XLEN-1:0]), p_q[XLEN-2:0], dge};
                    else
                        p_d = {msum, p_q[XLEN-1:1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(XLEN-1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                    if (!is_div_q) begin
                        hi_d = prod[2*XLEN-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end else if (dz_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            rs_q       <= '0;
            b_q        <= '0;
            p_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            rs_q       <= rs_d;
            b_q        <= b_d;
            p_q        <= p_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        cancel;
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Caller is at a negedge. Returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs_val = '0; rt_val = '0;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 0; op = 0; rs_val = 0; rt_val = 0;
        cancel = 0; wr_hi = 0; wr_lo = 0; wr_data = 0;
        #1;
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_zero});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo});
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu;
        int lat, bcnt;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", lat); end
        checks++;
        if (bcnt !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bcnt); end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            failures++; $display("FAIL multu_result got=%h exp=fffffffe00000001", {hi, lo});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    endtask

    task automatic test_mult;
        int lat, bcnt;
        run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin
            failures++; $display("FAIL mult_neg got=%h exp=fffffffffffffffe", {hi, lo});
        end
        run_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'h3FFFFFFF_00000001) begin
            failures++; $display("FAIL mult_max got=%h exp=3fffffff00000001", {hi, lo});
        end
    endtask

    task automatic test_div;
        int lat, bcnt;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            failures++; $display("FAIL div_neg got=%h exp=fffffffffffffffd", {hi, lo});
        end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
        run_op(OP_DIVU, 32'd7, 32'd2, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'h00000001_00000003) begin
            failures++; $display("FAIL divu_7_2 got=%h exp=0000000100000003", {hi, lo});
        end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        if ({hi, lo, div_zero} !== {64'h00000000_80000000, 1'b0}) begin
            failures++; $display("FAIL div_overflow got=%h/%b exp=0000000080000000/0", {hi, lo}, div_zero);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        run_op(OP_DIVU, 32'h1234, 32'd0, lat, bcnt);
        checks++;
        if ({hi, lo, div_zero} !== {32'h1234, 32'hFFFFFFFF, 1'b1}) begin
            failures++; $display("FAIL divzero got=%h/%b exp=00001234ffffffff/1", {hi, lo}, div_zero);
        end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL divzero_latency got=%0d exp=33", lat); end
        run_op(OP_DIVU, 32'd9, 32'd3, lat, bcnt);
        checks++;
        if ({hi, lo, div_zero} !== {32'd0, 32'd3, 1'b0}) begin
            failures++; $display("FAIL divzero_clear got=%h/%b exp=0000000000000003/0", {hi, lo}, div_zero);
        end
    endtask

    task automatic test_cancel;
        int seen_done;
        wr_hi = 1'b1; wr_data = 32'hAAAA;
        @(negedge clk);
        wr_hi = 1'b0;
        checks++;
        if (hi !== 32'hAAAA) begin failures++; $display("FAIL mthi got=%h exp=0000aaaa", hi); end
        op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            wr_lo = (c == 7); wr_data = 32'h5555;
            if (done) seen_done++;
        end
        wr_lo = 1'b0;
        checks++;
        if (lo !== 32'd3) begin failures++; $display("FAIL mtlo_while_busy got=%h exp=00000003", lo); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", seen_done); end
        checks++;
        if ({hi, lo, div_zero} !== {32'hAAAA, 32'd3, 1'b0}) begin
            failures++; $display("FAIL cancel_hilo got=%h/%b exp=0000aaaa00000003/0", {hi, lo}, div_zero);
        end
        start = 1'b1; cancel = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL cancel_beats_start got=%b exp=0", busy); end
    endtask

    task automatic test_ignore_start;
        int lat, dones;
        op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                start = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
        checks++;
        if ({hi, lo} !== 64'd9) begin failures++; $display("FAIL ignore_result got=%h exp=9", {hi, lo}); end
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL ignore_no_queue got=%0d exp=0", dones); end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_op(OP_DIVU, 32'd7, 32'd2, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'h00000001_00000003) begin
            failures++; $display("FAIL b2b_first got=%h exp=0000000100000003", {hi, lo});
        end
        run_op(OP_MULTU, 32'd6, 32'd7, lat, bcnt);
        checks++;
        if (lat !== 33 || bcnt !== 33) begin
            failures++; $display("FAIL b2b_latency got=%0d/%0d exp=33/33", lat, bcnt);
        end
        checks++;
        if ({hi, lo} !== 64'd42) begin failures++; $display("FAIL b2b_second got=%h exp=42", {hi, lo}); end
    endtask

    task automatic test_reset_mid;
        int dones;
        wr_hi = 1'b1; wr_data = 32'h1111;
        @(negedge clk);
        wr_hi = 1'b0;
        op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
            failures++; $display("FAIL async_reset got=%b/%b/%b/%h/%h exp=all 0", busy, done, div_zero, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", dones); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
